// File: rtl/key_debounce_multi.sv
// Multi-channel key conditioner: 2-flop sync, shared sample tick, per-channel
// stability filter, press/release pulses and optional auto-repeat.
module key_debounce_multi #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned TICK_DIV     = 16,
  parameter int unsigned STABLE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY = 32,
  parameter int unsigned REPEAT_RATE  = 8,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] key_raw_i,
  input  logic [CHANNELS-1:0] repeat_en_i,
  output logic [CHANNELS-1:0] key_level_o,
  output logic [CHANNELS-1:0] key_press_o,
  output logic [CHANNELS-1:0] key_release_o,
  output logic [CHANNELS-1:0] key_repeat_o,
  output logic                tick_o
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW   = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam int unsigned RMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = (RMax > 1) ? $clog2(RMax) : 1;
  localparam logic [CHANNELS-1:0] Released = (ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

  logic [CHANNELS-1:0]         sync1_q, sync2_q, pressed_s;
  logic [PW-1:0]               presc_q, presc_d;
  logic                        tick;
  logic [CHANNELS-1:0]         level_q, level_d, rise, fall, rep;
  logic [CHANNELS-1:0][SW-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0][RW-1:0] rcnt_q, rcnt_d;
  rep_state_e                  st_q [CHANNELS];
  rep_state_e                  st_d [CHANNELS];
  logic [CHANNELS-1:0]         press_q, release_q, repeat_q;

  assign pressed_s = sync2_q ^ Released;
  assign tick      = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d   = tick ? '0 : presc_q + PW'(1);

  // Filter: a level change needs STABLE_TICKS consecutive disagreeing ticks.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = '0;
    fall    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tick) begin
        if (pressed_s[i] != level_q[i]) begin
          if (cnt_q[i] == SW'(STABLE_TICKS - 1)) begin
            level_d[i] = ~level_q[i];
            cnt_d[i]   = '0;
            rise[i]    = ~level_q[i];
            fall[i]    = level_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + SW'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Release and disable take priority, so a releasing tick never repeats.
  always_comb begin
    st_d   = st_q;
    rcnt_d = rcnt_q;
    rep    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (fall[i] || !repeat_en_i[i]) begin
        st_d[i]   = StIdle;
        rcnt_d[i] = '0;
      end else begin
        case (st_q[i])
          StIdle: begin
            if (rise[i]) begin
              st_d[i]   = StDelay;
              rcnt_d[i] = '0;
            end
          end
          StDelay: begin
            if (tick) begin
              if (rcnt_q[i] == RW'(REPEAT_DELAY - 1)) begin
                rep[i]    = 1'b1;
                rcnt_d[i] = '0;
                st_d[i]   = StRepeat;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
              end
            end
          end
          StRepeat: begin
            if (tick) begin
              if (rcnt_q[i] == RW'(REPEAT_RATE - 1)) begin
                rep[i]    = 1'b1;
                rcnt_d[i] = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + RW'(1);
              end
            end
          end
          default: st_d[i] = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= Released;
      sync2_q   <= Released;
      presc_q   <= '0;
      level_q   <= '0;
      cnt_q     <= '0;
      rcnt_q    <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        st_q[i] <= StIdle;
      end
    end else begin
      sync1_q   <= key_raw_i;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      rcnt_q    <= rcnt_d;
      press_q   <= rise;
      release_q <= fall;
      repeat_q  <= rep;
      st_q      <= st_d;
    end
  end

  assign key_level_o   = level_q;
  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_repeat_o  = repeat_q;
  assign tick_o        = tick;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed phases; expected pulse events are
// queued with their exact clock and matched as the DUT emits them.
module tb_key_debounce_multi;
  localparam int TickDiv     = 4;
  localparam int StableTicks = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] key_raw = 2'b11;
  logic [1:0] repeat_en = 2'b00;
  logic [1:0] key_level, key_press, key_release, key_repeat;
  logic       tick;

  int total = 0;
  int bad   = 0;
  int cyc;

  typedef struct {
    int kind;  // 0 press, 1 release, 2 repeat
    int ch;
    int cyc;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  logic [2:0] mon_hits;

  key_debounce_multi #(
    .CHANNELS    (2),
    .TICK_DIV    (TickDiv),
    .STABLE_TICKS(StableTicks),
    .REPEAT_DELAY(5),
    .REPEAT_RATE (2),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_raw_i    (key_raw),
    .repeat_en_i  (repeat_en),
    .key_level_o  (key_level),
    .key_press_o  (key_press),
    .key_release_o(key_release),
    .key_repeat_o (key_repeat),
    .tick_o       (tick)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; tick cycles are those with cyc % 4 == 3.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      total++;
      assert ({key_level, key_press, key_release, key_repeat, tick} === 9'd0)
      else begin
        bad++;
        $error("FAIL reset_outputs got=%b want=0",
               {key_level, key_press, key_release, key_repeat, tick});
      end
    end else begin
      total++;
      assert (tick === (cyc % TickDiv == TickDiv - 1))
      else begin
        bad++;
        $error("FAIL tick cyc=%0d got=%b want=%b", cyc, tick, cyc % TickDiv == TickDiv - 1);
      end
      for (int ch = 0; ch < 2; ch++) begin
        mon_hits = {key_repeat[ch], key_release[ch], key_press[ch]};
        for (int k = 0; k < 3; k++) begin
          if (mon_hits[k]) begin
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else                  mon_e = '{kind: -1, ch: -1, cyc: -1};
            total++;
            assert (mon_e.kind == k && mon_e.ch == ch && mon_e.cyc == cyc)
            else begin
              bad++;
              $error("FAIL event got kind=%0d ch=%0d cyc=%0d want kind=%0d ch=%0d cyc=%0d",
                     k, ch, cyc, mon_e.kind, mon_e.ch, mon_e.cyc);
            end
          end
        end
      end
    end
  end

  // Clock in which the pulse shows up after a raw change driven in cycle c.
  function automatic int settle(input int c);
    int t;
    t = c + 2;
    while (t % TickDiv != TickDiv - 1) t++;
    return t + (StableTicks - 1) * TickDiv + 1;
  endfunction

  task automatic push(input int kind, input int ch, input int at);
    exp_q.push_back('{kind: kind, ch: ch, cyc: at});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drained(input string tag);
    total++;
    assert (exp_q.size() == 0)
    else begin
      bad++;
      $error("FAIL %s pending_events got=%0d want=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_level(input logic [1:0] want, input string tag);
    total++;
    assert (key_level === want)
    else begin
      bad++;
      $error("FAIL %s key_level got=%b want=%b", tag, key_level, want);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc;
    // Reset with keys released (pins high)
    #3 rst_n = 1'b0;
    step(4);
    #2 rst_n = 1'b1;
    step(8);
    check_level(2'b00, "after_reset");

    // Clean press on ch0 without repeat
    key_raw = 2'b10;
    push(0, 0, settle(cyc));
    step(20);
    drained("clean_press");
    check_level(2'b01, "clean_press");
    key_raw = 2'b11;
    push(1, 0, settle(cyc));
    step(20);
    drained("clean_release");
    check_level(2'b00, "clean_release");

    // Bounce every 5 clk must be rejected
    for (int i = 0; i < 12; i++) begin
      key_raw[0] = ~key_raw[0];
      step(5);
    end
    drained("bounce");
    check_level(2'b00, "bounce");
    key_raw[0] = 1'b0;
    push(0, 0, settle(cyc));
    step(20);
    drained("after_bounce_press");
    key_raw[0] = 1'b1;
    push(1, 0, settle(cyc));
    step(20);
    drained("after_bounce_release");

    // Auto-repeat; release lands on the 21st tick, which would have repeated
    repeat_en = 2'b01;
    key_raw[0] = 1'b0;
    pc = settle(cyc);
    push(0, 0, pc);
    for (int k = 5; k <= 19; k += 2) push(2, 0, pc + 4 * k);
    wait_until(pc + 72);
    key_raw[0] = 1'b1;
    push(1, 0, settle(cyc));
    step(25);
    drained("repeat_train");
    check_level(2'b00, "repeat_train");

    // Disabling repeat mid-hold disarms until the next press
    key_raw[0] = 1'b0;
    pc = settle(cyc);
    push(0, 0, pc);
    push(2, 0, pc + 20);
    push(2, 0, pc + 28);
    wait_until(pc + 30);
    repeat_en = 2'b00;
    wait_until(pc + 34);
    repeat_en = 2'b01;
    wait_until(pc + 80);
    drained("repeat_disarm_held");
    key_raw[0] = 1'b1;
    push(1, 0, settle(cyc));
    step(20);
    drained("repeat_disarm_release");

    // Reset mid-hold, then both channels re-detected together
    repeat_en = 2'b00;
    key_raw = 2'b10;
    push(0, 0, settle(cyc));
    step(20);
    drained("hold_before_reset");
    check_level(2'b01, "hold_before_reset");
    #2 rst_n = 1'b0;
    key_raw = 2'b00;
    #1;
    total++;
    assert ({key_level, key_press, key_release, key_repeat} === 8'd0)
    else begin
      bad++;
      $error("FAIL async_reset got=%b want=0", {key_level, key_press, key_release, key_repeat});
    end
    step(3);
    #2 rst_n = 1'b1;
    push(0, 0, settle(0));
    push(0, 1, settle(0));
    step(20);
    drained("repress_after_reset");
    check_level(2'b11, "repress_after_reset");
    key_raw = 2'b11;
    push(1, 0, settle(cyc));
    push(1, 1, settle(cyc));
    step(20);
    drained("dual_release");
    check_level(2'b00, "dual_release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
